uart_cfg_frame_parser: RTL and testbench

//  Consumes the byte stream from the UART receiver in dds_sample_top and assembles
//  14-byte config frames: 0x55 | 11 payload bytes | checksum | 0xAA.

---
 rtl/uart_cfg_frame_parser.sv | 142 ++++++++++++++
 tb/tb_uart_cfg_frame_parser.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cfg_frame_parser.sv
// Assembles 14-byte UART config frames (0x55 | 11 payload | checksum | 0xAA) into PWM/DDS config registers.
// Optional macro FRAME_CHECK_EN enables checksum comparison; without it the checksum byte is consumed unchecked.
module uart_cfg_frame_parser #(
  parameter logic [7:0]  HEADER       = 8'h55,
  parameter logic [7:0]  TAILER       = 8'hAA,
  parameter int unsigned TIMEOUT_CLKS = 20000
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        rx_done,
  input  logic [7:0]  rx_data,
  output logic [7:0]  reg_func,
  output logic [7:0]  hs_pwm_ch,
  output logic [7:0]  hs_ctrl_sta,
  output logic [7:0]  duty_num,
  output logic [15:0] pulse_dessert,
  output logic [7:0]  pulse_num,
  output logic [31:0] pat,
  output logic        cfg_valid,
  output logic        frame_err,
  output logic [1:0]  err_code,
  output logic [15:0] frame_ok_cnt
);

  // state   | meaning
  // IDLE    | hunting for HEADER, other bytes dropped
  // PAYLOAD | storing the 11 payload bytes into the shadow buffer
  // CHECK   | next byte is the checksum
  // TAIL    | next byte must be TAILER; commit or reject the frame
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PAYLOAD = 2'd1;
  localparam logic [1:0] ST_CHECK   = 2'd2;
  localparam logic [1:0] ST_TAIL    = 2'd3;

  localparam int unsigned    TMO_W    = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CLKS - 1);

  logic [1:0]       state;
  logic [3:0]       idx;
  logic [7:0]       shadow [0:10];
  logic [TMO_W-1:0] tmo_left;
  logic             tmo_fire;
  logic             bad_sum;

  // Down-counter reaches zero on the TIMEOUT_CLKS-th silent cycle; a byte in that cycle wins.
  assign tmo_fire = (state != ST_IDLE) && !rx_done && (tmo_left == '0);

`ifdef FRAME_CHECK_EN
  logic [7:0] sum;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sum     <= '0;
      bad_sum <= 1'b0;
    end else if (rx_done) begin
      case (state)
        ST_IDLE:    sum     <= '0;
        ST_PAYLOAD: sum     <= sum + rx_data;
        ST_CHECK:   bad_sum <= (rx_data != sum);
        default:    ;
      endcase
    end
  end
`else
  assign bad_sum = 1'b0;
`endif

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state         <= ST_IDLE;
      idx           <= '0;
      tmo_left      <= '0;
      for (int i = 0; i < 11; i++) shadow[i] <= '0;
      reg_func      <= '0;
      hs_pwm_ch     <= '0;
      hs_ctrl_sta   <= '0;
      duty_num      <= '0;
      pulse_dessert <= '0;
      pulse_num     <= '0;
      pat           <= '0;
      cfg_valid     <= 1'b0;
      frame_err     <= 1'b0;
      err_code      <= '0;
      frame_ok_cnt  <= '0;
    end else begin
      cfg_valid <= 1'b0;
      frame_err <= 1'b0;

      if (rx_done)
        tmo_left <= TMO_LOAD;
      else if (state != ST_IDLE && tmo_left != '0)
        tmo_left <= tmo_left - TMO_W'(1);

      if (tmo_fire) begin
        frame_err <= 1'b1;
        err_code  <= 2'b11;
        state     <= ST_IDLE;
      end else if (rx_done) begin
        case (state)
          ST_IDLE: begin
            if (rx_data == HEADER) begin
              state <= ST_PAYLOAD;
              idx   <= '0;
            end
          end
          ST_PAYLOAD: begin
            shadow[idx] <= rx_data;
            if (idx == 4'd10)
              state <= ST_CHECK;
            else
              idx <= idx + 4'd1;
          end
          ST_CHECK: state <= ST_TAIL;
          ST_TAIL: begin
            state <= ST_IDLE;
            // A bad tail outranks a bad checksum.
            if (rx_data != TAILER) begin
              frame_err <= 1'b1;
              err_code  <= 2'b10;
            end else if (bad_sum) begin
              frame_err <= 1'b1;
              err_code  <= 2'b01;
            end else begin
              reg_func      <= shadow[0];
              hs_pwm_ch     <= shadow[1];
              hs_ctrl_sta   <= shadow[2];
              duty_num      <= shadow[3];
              pulse_dessert <= {shadow[4], shadow[5]};
              pulse_num     <= shadow[6];
              pat           <= {shadow[7], shadow[8], shadow[9], shadow[10]};
              cfg_valid     <= 1'b1;
              if (frame_ok_cnt != 16'hFFFF)
                frame_ok_cnt <= frame_ok_cnt + 16'd1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_cfg_frame_parser.sv
// Self-checking bench for uart_cfg_frame_parser: spec scenarios, timeout boundary, reset abort, random frames.
module tb_uart_cfg_frame_parser;

  localparam int T = 20000;
`ifdef FRAME_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        rx_done = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic [7:0]  reg_func, hs_pwm_ch, hs_ctrl_sta, duty_num, pulse_num;
  logic [15:0] pulse_dessert, frame_ok_cnt;
  logic [31:0] pat;
  logic        cfg_valid, frame_err;
  logic [1:0]  err_code;

  uart_cfg_frame_parser dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .rx_done(rx_done), .rx_data(rx_data),
    .reg_func(reg_func), .hs_pwm_ch(hs_pwm_ch), .hs_ctrl_sta(hs_ctrl_sta),
    .duty_num(duty_num), .pulse_dessert(pulse_dessert), .pulse_num(pulse_num),
    .pat(pat), .cfg_valid(cfg_valid), .frame_err(frame_err), .err_code(err_code),
    .frame_ok_cnt(frame_ok_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  logic [105:0] dut_vec;
  assign dut_vec = {reg_func, hs_pwm_ch, hs_ctrl_sta, duty_num, pulse_dessert,
                    pulse_num, pat, frame_ok_cnt, err_code};

  // Reference model: payload bytes as last accepted, counters, last error code
  logic [7:0]  m_pay [11];
  logic [15:0] m_cnt;
  logic [1:0]  m_err;
  bit          exp_v, exp_e;
  int          e_valid = 0, e_err = 0;
  int          n_valid = 0, n_err = 0;
  int          n_checks = 0, n_pass = 0;
  logic [7:0]  fr [14];

  always @(negedge sys_clk) begin
    if (cfg_valid === 1'b1) n_valid++;
    if (frame_err === 1'b1) n_err++;
  end

  function automatic logic [105:0] exp_vec();
    logic [87:0] p = '0;
    for (int i = 0; i < 11; i++) p = {p[79:0], m_pay[i]};
    return {p, m_cnt, m_err};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 11; i++) m_pay[i] = 8'h00;
    m_cnt = 16'h0;
    m_err = 2'b00;
  endtask

  task automatic model_frame();
    int s = 0;
    for (int i = 1; i <= 11; i++) s += int'(fr[i]);
    exp_v = 1'b0;
    exp_e = 1'b0;
    if (fr[13] != 8'hAA) begin
      exp_e = 1'b1; m_err = 2'b10; e_err++;
    end else if (CHK_EN && fr[12] != 8'(s)) begin
      exp_e = 1'b1; m_err = 2'b01; e_err++;
    end else begin
      exp_v = 1'b1;
      for (int i = 0; i < 11; i++) m_pay[i] = fr[i+1];
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      e_valid++;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge sys_clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    @(posedge sys_clk); #1;
    rx_done = 1'b0;
    rx_data = 8'($urandom);
  endtask

  task automatic send_frame(input int max_gap);
    for (int i = 0; i < 14; i++) begin
      send_byte(fr[i]);
      if (i < 13 && max_gap > 0) idle(int'($urandom_range(max_gap, 0)));
    end
  endtask

  task automatic load_frame(input logic [111:0] v);
    for (int i = 0; i < 14; i++) fr[i] = v[111 - 8*i -: 8];
  endtask

  task automatic build_random(input int kind);
    int s = 0;
    fr[0] = 8'h55;
    for (int i = 1; i <= 11; i++) begin
      fr[i] = 8'($urandom);
      s += int'(fr[i]);
    end
    fr[12] = 8'(s);
    fr[13] = 8'hAA;
    if (kind[0]) fr[12] = fr[12] ^ 8'($urandom_range(255, 1));
    if (kind[1]) fr[13] = 8'hAA ^ 8'($urandom_range(255, 1));
  endtask

  task automatic apply_reset(input int n);
    sys_rst = 1'b1;
    idle(n);
    sys_rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    apply_reset(3);
    n_checks++;
    if (dut_vec !== 106'b0) $display("FAIL reset_outputs got=%h exp=0", dut_vec);
    else n_pass++;
    n_checks++;
    if ({cfg_valid, frame_err} !== 2'b00) $display("FAIL reset_strobes got=%b exp=00", {cfg_valid, frame_err});
    else n_pass++;
  endtask

  task automatic test_spec_frames();
    logic [111:0] s1 = 112'h55_01_01_01_03_00_44_00_00_00_00_FF_49_AA;
    logic [111:0] s3 = 112'h55_01_02_01_FF_07_30_00_FF_FF_FF_FF_36_AA;
    // scenario 1
    load_frame(s1); send_frame(0); model_frame();
    n_checks++;
    if ({cfg_valid, frame_err} !== {exp_v, exp_e}) $display("FAIL s1_strobe got=%b exp=%b", {cfg_valid, frame_err}, {exp_v, exp_e});
    else n_pass++;
    n_checks++;
    if ({reg_func, hs_pwm_ch, hs_ctrl_sta, duty_num, pulse_dessert, pulse_num, pat, frame_ok_cnt} !== 104'h01_01_01_03_0044_00_000000FF_0001)
      $display("FAIL s1_values got=%h", dut_vec);
    else n_pass++;
    // scenario 2: wrong checksum
    load_frame(s1); fr[12] = 8'h1A; send_frame(1); model_frame();
    n_checks++;
    if ({cfg_valid, frame_err} !== {exp_v, exp_e}) $display("FAIL s2_strobe got=%b exp=%b", {cfg_valid, frame_err}, {exp_v, exp_e});
    else n_pass++;
    n_checks++;
    if (dut_vec !== exp_vec()) $display("FAIL s2_outputs got=%h exp=%h", dut_vec, exp_vec());
    else n_pass++;
    // scenario 3: leading junk ignored
    send_byte(8'h00); send_byte(8'hAA); idle(2);
    load_frame(s3); send_frame(2); model_frame();
    n_checks++;
    if (cfg_valid !== 1'b1 || frame_err !== 1'b0) $display("FAIL s3_strobe got=%b exp=10", {cfg_valid, frame_err});
    else n_pass++;
    n_checks++;
    if (dut_vec !== exp_vec() || pat !== 32'hFFFFFFFF || pulse_dessert !== 16'h0730)
      $display("FAIL s3_outputs got=%h exp=%h", dut_vec, exp_vec());
    else n_pass++;
    // scenario 4: bad tail
    load_frame(s1); fr[13] = 8'hAB; send_frame(1); model_frame();
    n_checks++;
    if (frame_err !== 1'b1 || cfg_valid !== 1'b0 || err_code !== 2'b10)
      $display("FAIL s4_tail_err got=%b code=%b exp=01 code=10", {cfg_valid, frame_err}, err_code);
    else n_pass++;
    n_checks++;
    if (dut_vec !== exp_vec()) $display("FAIL s4_outputs got=%h exp=%h", dut_vec, exp_vec());
    else n_pass++;
    idle(2);
    n_checks++;
    if (n_valid != e_valid || n_err != e_err)
      $display("FAIL spec_strobe_counts got=%0d/%0d exp=%0d/%0d", n_valid, n_err, e_valid, e_err);
    else n_pass++;
  endtask

  task automatic test_timeout();
    logic [111:0] s1 = 112'h55_01_01_01_03_00_44_00_00_00_00_FF_49_AA;
    load_frame(s1);
    for (int i = 0; i < 6; i++) send_byte(fr[i]);
    idle(T - 1);
    n_checks++;
    if (frame_err !== 1'b0) $display("FAIL tmo_early got=%b exp=0", frame_err);
    else n_pass++;
    idle(1);
    m_err = 2'b11; e_err++;
    n_checks++;
    if (frame_err !== 1'b1 || dut_vec !== exp_vec())
      $display("FAIL tmo_fire got=%b vec=%h exp=1 vec=%h", frame_err, dut_vec, exp_vec());
    else n_pass++;
    idle(1);
    load_frame(s1); send_frame(0); model_frame();
    n_checks++;
    if (cfg_valid !== 1'b1 || dut_vec !== exp_vec())
      $display("FAIL tmo_recover got=%b vec=%h exp=1 vec=%h", cfg_valid, dut_vec, exp_vec());
    else n_pass++;
    // byte arriving exactly in the expiry cycle keeps the frame alive
    build_random(0);
    for (int i = 0; i < 6; i++) send_byte(fr[i]);
    idle(T - 1);
    for (int i = 6; i < 14; i++) send_byte(fr[i]);
    model_frame();
    n_checks++;
    if (cfg_valid !== 1'b1 || dut_vec !== exp_vec())
      $display("FAIL tmo_boundary got=%b vec=%h exp=1 vec=%h", cfg_valid, dut_vec, exp_vec());
    else n_pass++;
    idle(2);
    n_checks++;
    if (n_valid != e_valid || n_err != e_err)
      $display("FAIL tmo_strobe_counts got=%0d/%0d exp=%0d/%0d", n_valid, n_err, e_valid, e_err);
    else n_pass++;
  endtask

  task automatic test_reset_midframe();
    logic [111:0] s1 = 112'h55_01_01_01_03_00_44_00_00_00_00_FF_49_AA;
    logic [111:0] s3 = 112'h55_01_02_01_FF_07_30_00_FF_FF_FF_FF_36_AA;
    load_frame(s1);
    for (int i = 0; i < 7; i++) send_byte(fr[i]);
    apply_reset(1);
    n_checks++;
    if (dut_vec !== 106'b0) $display("FAIL midreset_outputs got=%h exp=0", dut_vec);
    else n_pass++;
    load_frame(s3); send_frame(1); model_frame();
    n_checks++;
    if (cfg_valid !== 1'b1 || frame_ok_cnt !== 16'd1 || dut_vec !== exp_vec())
      $display("FAIL midreset_fresh got=%b vec=%h exp=1 vec=%h", cfg_valid, dut_vec, exp_vec());
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 3; k++) begin
      build_random(0); send_frame(0); model_frame();
      n_checks++;
      if (cfg_valid !== 1'b1 || dut_vec !== exp_vec())
        $display("FAIL b2b_%0d got=%b vec=%h exp=1 vec=%h", k, cfg_valid, dut_vec, exp_vec());
      else n_pass++;
    end
    idle(2);
    n_checks++;
    if (n_valid != e_valid || n_err != e_err)
      $display("FAIL b2b_strobe_counts got=%0d/%0d exp=%0d/%0d", n_valid, n_err, e_valid, e_err);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int k = 0; k < 40; k++) begin
      int junk = int'($urandom_range(2, 0));
      for (int j = 0; j < junk; j++) begin
        logic [7:0] b = 8'($urandom);
        if (b == 8'h55) b = 8'h56;
        send_byte(b);
      end
      build_random(int'($urandom_range(3, 0)));
      send_frame(3);
      model_frame();
      n_checks++;
      if ({cfg_valid, frame_err} !== {exp_v, exp_e})
        $display("FAIL rand_strobe_%0d got=%b exp=%b", k, {cfg_valid, frame_err}, {exp_v, exp_e});
      else n_pass++;
      n_checks++;
      if (dut_vec !== exp_vec()) $display("FAIL rand_outputs_%0d got=%h exp=%h", k, dut_vec, exp_vec());
      else n_pass++;
    end
    idle(2);
    n_checks++;
    if (n_valid != e_valid || n_err != e_err)
      $display("FAIL rand_strobe_counts got=%0d/%0d exp=%0d/%0d", n_valid, n_err, e_valid, e_err);
    else n_pass++;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    test_reset();
    test_spec_frames();
    test_timeout();
    test_reset_midframe();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
